// File: rtl/tdr_ctrl_pkg.sv
// Shared types for the TDR scan-chain controller: FSM states, request flags
// and the default chain length.
package tdr_ctrl_pkg;

    localparam int unsigned DEFAULT_CHAIN_LEN = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_SHIFT,
        ST_UPDATE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic do_capture;
        logic do_update;
    } req_flags_t;

endpackage

// File: rtl/tdr_scan_controller_if.sv
// Parallel request/response bundle between the config master and the
// scan controller.
interface tdr_scan_controller_if
    import tdr_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN
);
    logic                 start;
    logic                 do_capture;
    logic                 do_update;
    logic [CHAIN_LEN-1:0] wdata;
    logic                 busy;
    logic                 done;
    logic [CHAIN_LEN-1:0] rdata;

    modport master (
        output start, do_capture, do_update, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, do_capture, do_update, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/tdr_shift_counter.sv
// Shift counter: counts enabled cycles, clears on request, flags the
// terminal count TERM.
module tdr_shift_counter #(
    parameter int unsigned CNT_W = 7,
    parameter int unsigned TERM  = 127
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(TERM));
endmodule

// File: rtl/tdr_scan_controller.sv
// Sequencer turning one parallel request into capture / CHAIN_LEN shifts /
// update on the TDR chain; every output is registered.
module tdr_scan_controller
    import tdr_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic                  tck,
    input  logic                  reset,
    tdr_scan_controller_if.slave  req,
    input  logic                  tdo,
    output logic                  tdi,
    output logic                  shift_en,
    output logic                  capture_en,
    output logic                  update_en
);
    state_t               state_q, state_d;
    req_flags_t           flags_q, flags_d;
    logic [CHAIN_LEN-1:0] tx_q, tx_d;
    logic [CHAIN_LEN-1:0] rx_q, rx_d;
    logic [CHAIN_LEN-1:0] rdata_q, rdata_d;
    logic                 tdi_q, tdi_d;
    logic                 shift_en_q, shift_en_d;
    logic                 capture_en_q, capture_en_d;
    logic                 update_en_q, update_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cnt_en, cnt_tc;

    assign cnt_en = (state_q == ST_SHIFT);

    tdr_shift_counter #(
        .CNT_W (CNT_W),
        .TERM  (CHAIN_LEN - 1)
    ) u_cnt (
        .clk_i (tck),
        .rst_i (reset),
        .clr_i (cnt_en && cnt_tc),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req.start) begin
                    flags_d.do_capture = req.do_capture;
                    flags_d.do_update  = req.do_update;
                    tx_d               = req.wdata;
                    state_d            = req.do_capture ? ST_CAPTURE : ST_SHIFT;
                end
            end
            ST_CAPTURE: state_d = flags_q.do_capture ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: begin
                tx_d = {tx_q[CHAIN_LEN-2:0], 1'b0};
                if (cnt_tc) begin
                    state_d = flags_q.do_update ? ST_UPDATE : ST_DONE;
                end
            end
            ST_UPDATE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        if (shift_en_q) begin
            rx_d = {rx_q[CHAIN_LEN-2:0], tdo};
        end
        // Outputs are decoded from the next state so the registered copies
        // line up with the state they belong to; tdi leads with tx MSB.
        if (state_d == ST_DONE) begin
            rdata_d = rx_d;
        end
        tdi_d        = (state_d == ST_SHIFT) && tx_d[CHAIN_LEN-1];
        shift_en_d   = (state_d == ST_SHIFT);
        capture_en_d = (state_d == ST_CAPTURE);
        update_en_d  = (state_d == ST_UPDATE);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            flags_q      <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            rdata_q      <= '0;
            tdi_q        <= 1'b0;
            shift_en_q   <= 1'b0;
            capture_en_q <= 1'b0;
            update_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            flags_q      <= flags_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            rdata_q      <= rdata_d;
            tdi_q        <= tdi_d;
            shift_en_q   <= shift_en_d;
            capture_en_q <= capture_en_d;
            update_en_q  <= update_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tdi        = tdi_q;
    assign shift_en   = shift_en_q;
    assign capture_en = capture_en_q;
    assign update_en  = update_en_q;
    assign req.busy   = busy_q;
    assign req.done   = done_q;
    assign req.rdata  = rdata_q;
endmodule

// File: tb/tb_tdr_scan_controller.sv
// Controller driving a 128-stage chain with inverting capture loopback,
// checked against a word-level model of chain and core registers.
module tb_tdr_scan_controller;
    localparam int CL = 128;

    logic tck = 1'b0;
    logic reset;
    logic tdo, tdi, shift_en, capture_en, update_en;

    tdr_scan_controller_if #(.CHAIN_LEN(CL)) ifc ();

    tdr_scan_controller #(.CHAIN_LEN(CL)) dut (
        .tck        (tck),
        .reset      (reset),
        .req        (ifc),
        .tdo        (tdo),
        .tdi        (tdi),
        .shift_en   (shift_en),
        .capture_en (capture_en),
        .update_en  (update_en)
    );

    always #5 tck = ~tck;

    // Chain plant: stage 0 takes tdi, last stage drives tdo; capture loads ~core.
    logic [CL-1:0] chain   = '0;
    logic [CL-1:0] to_core = '0;
    assign tdo = chain[CL-1];

    always @(posedge tck) begin
        if (capture_en)    chain <= ~to_core;
        else if (shift_en) chain <= {chain[CL-2:0], tdi};
    end

    always @(negedge tck) begin
        if (update_en) to_core <= chain;
    end

    int checks = 0, errors = 0;
    int n_shift = 0, n_cap = 0, n_upd = 0, n_done = 0, ops_done = 0;
    int overlap = 0, tdi_bad = 0, idle_bad = 0;

    logic [CL-1:0] ref_chain = '0;
    logic [CL-1:0] ref_core  = '0;

    task automatic chk(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge tck) begin
        if (!reset) begin
            if (shift_en)   n_shift++;
            if (capture_en) n_cap++;
            if (update_en)  n_upd++;
            if (ifc.done)   n_done++;
            if ((int'(shift_en) + int'(capture_en) + int'(update_en)) > 1) overlap++;
            if (tdi && !shift_en) tdi_bad++;
            if (!ifc.busy && (shift_en || capture_en || update_en)) idle_bad++;
        end
    end

    function automatic logic [CL-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge tck);
        while (ifc.busy && n < 400) begin
            @(negedge tck);
            n++;
        end
        chk("idle_wait", ifc.busy, 1'b0);
    endtask

    task automatic op(input logic [CL-1:0] wd, input logic cap, input logic upd,
                      input logic hold, input logic inject);
        logic [CL-1:0] exp_r;
        bit seen = 0;
        int n = 0;
        wait_idle();
        n_shift = 0; n_cap = 0; n_upd = 0;
        ifc.start = 1'b1; ifc.wdata = wd; ifc.do_capture = cap; ifc.do_update = upd;
        while (!seen && n < 300) begin
            @(posedge tck); #1;
            n++;
            if (n == 1) begin
                ifc.wdata = ~wd;
                if (!hold) begin
                    ifc.start = 1'b0; ifc.do_capture = ~cap; ifc.do_update = ~upd;
                end
            end
            if (inject && !hold && n == 50) begin
                ifc.start = 1'b1; ifc.wdata = rnd128();
            end
            if (inject && !hold && n == 51) ifc.start = 1'b0;
            if (ifc.done) seen = 1;
        end
        chk("done_seen", seen, 1'b1);
        chk("latency", n, CL + 1 + int'(cap) + int'(upd));
        if (seen) ops_done++;

        if (cap) ref_chain = ~ref_core;
        exp_r     = ref_chain;
        ref_chain = wd;
        if (upd) ref_core = wd;

        chk("rdata", ifc.rdata, exp_r);
        chk("to_core", to_core, ref_core);
        chk("n_shift", n_shift, CL);
        chk("n_capture", n_cap, cap);
        chk("n_update", n_upd, upd);
        @(posedge tck); #1;
        chk("done_width", ifc.done, 1'b0);
        chk("busy_after_done", ifc.busy, 1'b0);
    endtask

    initial begin
        logic [CL-1:0] w0, wr;
        int k;
        w0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        reset = 1'b1;
        ifc.start = 1'b0; ifc.do_capture = 1'b0; ifc.do_update = 1'b0; ifc.wdata = '0;
        repeat (3) @(negedge tck);
        chk("rst_ctrl", {tdi, shift_en, capture_en, update_en, ifc.busy, ifc.done}, '0);
        chk("rst_rdata", ifc.rdata, '0);
        reset = 1'b0;

        op(w0, 1'b0, 1'b1, 1'b0, 1'b0);
        op(w0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rdata_inv", ifc.rdata, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF);
        op({(CL/2){2'b10}}, 1'b0, 1'b0, 1'b0, 1'b0);
        op('1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rdata_aaaa", ifc.rdata, {(CL/2){2'b10}});

        for (int i = 0; i < 3; i++) op(rnd128(), 1'b1, 1'b1, 1'b1, 1'b0);
        ifc.start = 1'b0;

        op(rnd128(), 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (5) @(negedge tck);
        chk("no_queued_op", ifc.busy, 1'b0);
        op(rnd128(), 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort after exactly 40 completed shifts.
        wr = rnd128();
        wait_idle();
        ifc.start = 1'b1; ifc.wdata = wr; ifc.do_capture = 1'b0; ifc.do_update = 1'b1;
        @(posedge tck); #1;
        ifc.start = 1'b0;
        k = 0;
        for (int i = 0; i < 200 && k < 41; i++) begin
            @(negedge tck);
            if (shift_en) k++;
        end
        chk("abort_reach", k, 41);
        reset = 1'b1;
        #1;
        chk("abort_ctrl", {tdi, shift_en, capture_en, update_en, ifc.busy, ifc.done}, '0);
        chk("abort_rdata", ifc.rdata, '0);
        ref_chain = (ref_chain << 40) | (wr >> (CL - 40));
        @(negedge tck);
        reset = 1'b0;
        chk("abort_core", to_core, ref_core);
        op(rnd128(), 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            op(rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
               1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge tck);
        chk("done_count", n_done, ops_done);
        chk("enable_overlap", overlap, 0);
        chk("tdi_outside_shift", tdi_bad, 0);
        chk("enable_while_idle", idle_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
